// File: rtl/cp0_irq_ctrl.sv
// cp0_irq_ctrl: CP0 register file with a multi-line, priority-encoded interrupt
// controller for the 5-stage MIPS core.
//   clk, rst           clock, synchronous active-high reset
//   oper               00 none, 01 MFC0, 10 MTC0, 11 ERET
//   addr_r / data_r    MFC0 address / combinational read data
//   addr_w / data_w    MTC0 address / write data
//   ir_en              pipeline can accept a fetch redirect this cycle
//   ir_in              level interrupt lines, line 0 highest priority
//   ret_addr           PC saved to EPC when an interrupt is taken
//   jump_en/jump_addr  combinational fetch redirect (take or ERET)
//   in_handler         handler state active
module cp0_irq_ctrl #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter int unsigned VECTORED   = 1,
    parameter int unsigned VEC_STRIDE = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [1:0]           oper,
    input  logic [4:0]           addr_r,
    output logic [31:0]          data_r,
    input  logic [4:0]           addr_w,
    input  logic [31:0]          data_w,
    input  logic                 ir_en,
    input  logic [NUM_IRQ-1:0]   ir_in,
    input  logic [31:0]          ret_addr,
    output logic                 jump_en,
    output logic [31:0]          jump_addr,
    output logic                 in_handler
);

    localparam int unsigned IDX_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [31:0] STRIDE_W   = 32'(VEC_STRIDE);
    localparam logic [1:0]  OP_MFC0    = 2'b01;
    localparam logic [1:0]  OP_MTC0    = 2'b10;
    localparam logic [1:0]  OP_ERET    = 2'b11;
    localparam logic [4:0]  REG_STATUS = 5'd0;
    localparam logic [4:0]  REG_CAUSE  = 5'd1;
    localparam logic [4:0]  REG_EPC    = 5'd2;
    localparam logic [4:0]  REG_EHBR   = 5'd3;

    typedef enum logic {S_IDLE, S_HANDLER} state_t;

    state_t               state_q, state_d;
    logic                 ie_q, ie_d;
    logic                 pie_q, pie_d;
    logic [NUM_IRQ-1:0]   im_q, im_d;
    logic [NUM_IRQ-1:0]   pend_q, pend_d;
    logic [4:0]           code_q, code_d;
    logic [31:0]          epc_q, epc_d;
    logic [31:0]          ehbr_q, ehbr_d;

    logic [NUM_IRQ-1:0]   req;
    logic [IDX_W-1:0]     idx;
    logic                 take;
    logic                 eret;
    logic                 mtc0_ok;
    logic [31:0]          vec_addr;
    logic [NUM_IRQ-1:0]   take_mask;
    logic [NUM_IRQ-1:0]   w1c_mask;
    logic [31:0]          status_word;
    logic [31:0]          cause_word;
    logic                 unused_c;

    // data_w bits above the implemented fields have no register behind them
    assign unused_c = ^data_w;

    assign req = pend_q & im_q;

    // Lowest set index wins; scanning downward lets the last hit be the lowest
    always_comb begin
        idx = '0;
        for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
            if (req[i]) begin
                idx = IDX_W'(i);
            end
        end
    end

    // A take pre-empts any ERET/MTC0 issued in the same cycle
    assign take    = !rst && (state_q == S_IDLE) && ie_q && ir_en && (|req);
    assign eret    = !rst && (oper == OP_ERET) && !take;
    assign mtc0_ok = (oper == OP_MTC0) && !take;

    assign vec_addr  = (VECTORED != 0) ? (ehbr_q + (32'(idx) * STRIDE_W)) : ehbr_q;
    assign take_mask = take ? (NUM_IRQ'(1) << idx) : '0;
    assign w1c_mask  = (mtc0_ok && (addr_w == REG_CAUSE)) ? data_w[NUM_IRQ+7:8] : '0;

    // Sticky pending: a line high this cycle overrides both W1C and take-clear
    assign pend_d = (pend_q & ~w1c_mask & ~take_mask) | ir_in;

    // Register next-state
    always_comb begin
        ie_d   = ie_q;
        pie_d  = pie_q;
        im_d   = im_q;
        code_d = code_q;
        epc_d  = epc_q;
        ehbr_d = ehbr_q;
        if (take) begin
            epc_d  = ret_addr;
            code_d = 5'(idx);
            pie_d  = ie_q;
            ie_d   = 1'b0;
        end else if (eret) begin
            ie_d = pie_q;
        end else if (mtc0_ok) begin
            case (addr_w)
                REG_STATUS: begin
                    ie_d  = data_w[0];
                    pie_d = data_w[1];
                    im_d  = data_w[NUM_IRQ+7:8];
                end
                REG_EPC:  epc_d  = data_w;
                REG_EHBR: ehbr_d = data_w;
                default: ;
            endcase
        end
    end

    // CP0 register bank
    always_ff @(posedge clk) begin
        if (rst) begin
            ie_q   <= 1'b0;
            pie_q  <= 1'b0;
            im_q   <= '0;
            pend_q <= '0;
            code_q <= '0;
            epc_q  <= '0;
            ehbr_q <= '0;
        end else begin
            ie_q   <= ie_d;
            pie_q  <= pie_d;
            im_q   <= im_d;
            pend_q <= pend_d;
            code_q <= code_d;
            epc_q  <= epc_d;
            ehbr_q <= ehbr_d;
        end
    end

    // Handler FSM: state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Handler FSM: next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:    if (take) state_d = S_HANDLER;
            S_HANDLER: if (eret) state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Handler FSM: outputs
    always_comb begin
        jump_en    = take || eret;
        jump_addr  = '0;
        in_handler = (state_q == S_HANDLER);
        if (take) begin
            jump_addr = vec_addr;
        end else if (eret) begin
            jump_addr = epc_q;
        end
    end

    // MFC0 read mux
    always_comb begin
        status_word                = '0;
        status_word[0]             = ie_q;
        status_word[1]             = pie_q;
        status_word[NUM_IRQ+7:8]   = im_q;
        cause_word                 = '0;
        cause_word[4:0]            = code_q;
        cause_word[NUM_IRQ+7:8]    = pend_q;
        data_r = '0;
        if (oper == OP_MFC0) begin
            case (addr_r)
                REG_STATUS: data_r = status_word;
                REG_CAUSE:  data_r = cause_word;
                REG_EPC:    data_r = epc_q;
                REG_EHBR:   data_r = ehbr_q;
                default:    data_r = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cp0_irq_ctrl.sv
// Testbench for cp0_irq_ctrl: a vectored and a fixed-address instance share
// all stimulus; expected values are queued at drive time and drained against
// observed values at the end of each scenario.
module tb_cp0_irq_ctrl;

    logic        clk;
    logic        rst;
    logic [1:0]  oper;
    logic [4:0]  addr_r;
    logic [4:0]  addr_w;
    logic [31:0] data_w;
    logic        ir_en;
    logic [3:0]  ir_in;
    logic [31:0] ret_addr;

    logic [31:0] data_r_v, data_r_f;
    logic        jump_en_v, jump_en_f;
    logic [31:0] jump_addr_v, jump_addr_f;
    logic        in_handler_v, in_handler_f;

    int n_assert;
    int n_fail;

    typedef struct {
        string       name;
        logic [31:0] val;
    } sb_t;

    sb_t exp_q[$];
    sb_t obs_q[$];

    cp0_irq_ctrl #(.NUM_IRQ(4), .VECTORED(1), .VEC_STRIDE(32)) dut_v (
        .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r_v),
        .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
        .ret_addr(ret_addr), .jump_en(jump_en_v), .jump_addr(jump_addr_v),
        .in_handler(in_handler_v)
    );

    cp0_irq_ctrl #(.NUM_IRQ(4), .VECTORED(0), .VEC_STRIDE(32)) dut_f (
        .clk(clk), .rst(rst), .oper(oper), .addr_r(addr_r), .data_r(data_r_f),
        .addr_w(addr_w), .data_w(data_w), .ir_en(ir_en), .ir_in(ir_in),
        .ret_addr(ret_addr), .jump_en(jump_en_f), .jump_addr(jump_addr_f),
        .in_handler(in_handler_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic exp_push(input string n, input logic [31:0] v);
        sb_t s;
        s.name = n;
        s.val  = v;
        exp_q.push_back(s);
    endtask

    task automatic obs_push(input string n, input logic [31:0] v);
        sb_t s;
        s.name = n;
        s.val  = v;
        obs_q.push_back(s);
    endtask

    // Every helper starts and ends 1 time unit after a rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        oper   = 2'b10;
        addr_w = a;
        data_w = d;
        tick();
        oper   = 2'b00;
    endtask

    task automatic mfc0(input logic [4:0] a, output logic [31:0] v, output logic [31:0] vf);
        oper   = 2'b01;
        addr_r = a;
        #1;
        v  = data_r_v;
        vf = data_r_f;
        tick();
        oper = 2'b00;
    endtask

    task automatic eret();
        oper = 2'b11;
        tick();
        oper = 2'b00;
    endtask

    task automatic test_reset();
        logic [31:0] v, vf;
        sb_t e, o;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;
        exp_push("rst_jump_en", 32'd0);      obs_push("rst_jump_en", 32'(jump_en_v));
        exp_push("rst_jump_addr", 32'd0);    obs_push("rst_jump_addr", jump_addr_v);
        exp_push("rst_in_handler", 32'd0);   obs_push("rst_in_handler", 32'(in_handler_v));
        for (int a = 0; a < 4; a++) begin
            mfc0(5'(a), v, vf);
            exp_push("rst_reg", 32'd0);
            obs_push("rst_reg", v);
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_assert++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL test_reset scoreboard: exp %0d obs %0d entries", exp_q.size(), obs_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
                end
            end
        end
    endtask

    task automatic test_irq_take();
        logic [31:0] v, vf;
        int lat;
        sb_t e, o;
        mtc0(5'd3, 32'h0000_0100);
        mtc0(5'd0, 32'h0000_0F01);
        ret_addr = 32'h40;
        ir_in    = 4'b0100;
        tick();
        ir_in = 4'b0000;
        #1;
        lat = 0;
        while (jump_en_v !== 1'b1 && lat < 8) begin
            tick();
            #1;
            lat++;
        end
        exp_push("take_latency", 32'd0);     obs_push("take_latency", 32'(lat));
        exp_push("take_vec_addr", 32'h140);  obs_push("take_vec_addr", jump_addr_v);
        exp_push("take_fix_addr", 32'h100);  obs_push("take_fix_addr", jump_addr_f);
        tick();
        #1;
        exp_push("hnd_in_handler", 32'd1);   obs_push("hnd_in_handler", 32'(in_handler_v));
        exp_push("hnd_jump_en", 32'd0);      obs_push("hnd_jump_en", 32'(jump_en_v));
        exp_push("hnd_jump_addr", 32'd0);    obs_push("hnd_jump_addr", jump_addr_v);
        mfc0(5'd2, v, vf);
        exp_push("hnd_epc", 32'h40);         obs_push("hnd_epc", v);
        mfc0(5'd1, v, vf);
        exp_push("hnd_cause", 32'h2);        obs_push("hnd_cause", v);
        mfc0(5'd0, v, vf);
        exp_push("hnd_status", 32'h0F02);    obs_push("hnd_status", v);
        oper = 2'b11;
        #1;
        exp_push("eret_jump_en", 32'd1);     obs_push("eret_jump_en", 32'(jump_en_v));
        exp_push("eret_jump_addr", 32'h40);  obs_push("eret_jump_addr", jump_addr_v);
        tick();
        oper = 2'b00;
        #1;
        exp_push("eret_in_handler", 32'd0);  obs_push("eret_in_handler", 32'(in_handler_v));
        mfc0(5'd0, v, vf);
        exp_push("eret_status", 32'h0F03);   obs_push("eret_status", v);
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_assert++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL test_irq_take scoreboard: exp %0d obs %0d entries", exp_q.size(), obs_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
                end
            end
        end
    endtask

    task automatic test_priority();
        logic [31:0] v, vf;
        sb_t e, o;
        ret_addr = 32'h80;
        ir_in    = 4'b1010;
        tick();
        ir_in = 4'b1000;
        #1;
        exp_push("prio_jump_en", 32'd1);     obs_push("prio_jump_en", 32'(jump_en_v));
        exp_push("prio_idx1_addr", 32'h120); obs_push("prio_idx1_addr", jump_addr_v);
        tick();
        ir_in = 4'b0000;
        mfc0(5'd1, v, vf);
        exp_push("prio_cause", 32'h801);     obs_push("prio_cause", v);
        oper = 2'b11;
        #1;
        exp_push("prio_eret_addr", 32'h80);  obs_push("prio_eret_addr", jump_addr_v);
        tick();
        oper = 2'b00;
        #1;
        exp_push("prio_retake_en", 32'd1);   obs_push("prio_retake_en", 32'(jump_en_v));
        exp_push("prio_idx3_addr", 32'h160); obs_push("prio_idx3_addr", jump_addr_v);
        exp_push("prio_idle", 32'd0);        obs_push("prio_idle", 32'(in_handler_v));
        tick();
        #1;
        exp_push("prio_hnd2", 32'd1);        obs_push("prio_hnd2", 32'(in_handler_v));
        mfc0(5'd1, v, vf);
        exp_push("prio_cause2", 32'h003);    obs_push("prio_cause2", v);
        eret();
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_assert++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL test_priority scoreboard: exp %0d obs %0d entries", exp_q.size(), obs_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
                end
            end
        end
    endtask

    task automatic test_ir_en();
        sb_t e, o;
        ir_en = 1'b0;
        ir_in = 4'b0001;
        tick();
        ir_in = 4'b0000;
        #1;
        exp_push("stall_jump_en", 32'd0);    obs_push("stall_jump_en", 32'(jump_en_v));
        tick();
        #1;
        exp_push("stall_jump_en2", 32'd0);   obs_push("stall_jump_en2", 32'(jump_en_v));
        exp_push("stall_idle", 32'd0);       obs_push("stall_idle", 32'(in_handler_v));
        ir_en = 1'b1;
        #1;
        exp_push("unstall_jump_en", 32'd1);  obs_push("unstall_jump_en", 32'(jump_en_v));
        exp_push("unstall_addr", 32'h100);   obs_push("unstall_addr", jump_addr_v);
        tick();
        #1;
        exp_push("unstall_hnd", 32'd1);      obs_push("unstall_hnd", 32'(in_handler_v));
        eret();
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_assert++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL test_ir_en scoreboard: exp %0d obs %0d entries", exp_q.size(), obs_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
                end
            end
        end
    endtask

    task automatic test_collision();
        logic [31:0] v, vf;
        sb_t e, o;
        ir_in = 4'b0100;
        tick();
        ir_in  = 4'b0000;
        oper   = 2'b10;
        addr_w = 5'd3;
        data_w = 32'h200;
        #1;
        exp_push("col_take_addr", 32'h140);  obs_push("col_take_addr", jump_addr_v);
        tick();
        oper = 2'b00;
        #1;
        exp_push("col_hnd", 32'd1);          obs_push("col_hnd", 32'(in_handler_v));
        mfc0(5'd3, v, vf);
        exp_push("col_ehbr_kept", 32'h100);  obs_push("col_ehbr_kept", v);
        eret();
        ir_in = 4'b0001;
        tick();
        ir_in = 4'b0000;
        oper  = 2'b11;
        #1;
        exp_push("col_eret_jump_en", 32'd1); obs_push("col_eret_jump_en", 32'(jump_en_v));
        exp_push("col_take_wins", 32'h100);  obs_push("col_take_wins", jump_addr_v);
        tick();
        oper = 2'b00;
        #1;
        exp_push("col_hnd2", 32'd1);         obs_push("col_hnd2", 32'(in_handler_v));
        mfc0(5'd0, v, vf);
        exp_push("col_status", 32'h0F02);    obs_push("col_status", v);
        eret();
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_assert++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL test_collision scoreboard: exp %0d obs %0d entries", exp_q.size(), obs_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
                end
            end
        end
    endtask

    task automatic test_fixed();
        logic [31:0] v, vf;
        sb_t e, o;
        mtc0(5'd0, 32'h0000_0001);
        ir_in = 4'b0001;
        tick();
        ir_in = 4'b0000;
        #1;
        exp_push("mask_jump_en_v", 32'd0);   obs_push("mask_jump_en_v", 32'(jump_en_v));
        exp_push("mask_jump_en_f", 32'd0);   obs_push("mask_jump_en_f", 32'(jump_en_f));
        mfc0(5'd1, v, vf);
        exp_push("mask_cause", 32'h100);     obs_push("mask_cause", vf);
        ir_in = 4'b0001;
        mtc0(5'd1, 32'h100);
        ir_in = 4'b0000;
        mfc0(5'd1, v, vf);
        exp_push("w1c_set_wins", 32'h100);   obs_push("w1c_set_wins", vf);
        mtc0(5'd1, 32'h100);
        mfc0(5'd1, v, vf);
        exp_push("w1c_cleared", 32'h000);    obs_push("w1c_cleared", vf);
        addr_r = 5'd3;
        #1;
        exp_push("no_mfc0_zero", 32'd0);     obs_push("no_mfc0_zero", data_r_f);
        mtc0(5'd0, 32'h0000_0F01);
        ret_addr = 32'h44;
        ir_in    = 4'b1000;
        tick();
        ir_in = 4'b0000;
        #1;
        exp_push("fix_jump_en", 32'd1);      obs_push("fix_jump_en", 32'(jump_en_f));
        exp_push("fix_jump_addr", 32'h100);  obs_push("fix_jump_addr", jump_addr_f);
        exp_push("vec_jump_addr", 32'h160);  obs_push("vec_jump_addr", jump_addr_v);
        tick();
        eret();
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_assert++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL test_fixed scoreboard: exp %0d obs %0d entries", exp_q.size(), obs_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] v, vf;
        sb_t e, o;
        ir_in = 4'b0110;
        tick();
        ir_in = 4'b0000;
        #1;
        exp_push("mid_take_addr", 32'h120);  obs_push("mid_take_addr", jump_addr_v);
        tick();
        #1;
        exp_push("mid_hnd", 32'd1);          obs_push("mid_hnd", 32'(in_handler_v));
        mfc0(5'd1, v, vf);
        exp_push("mid_cause", 32'h401);      obs_push("mid_cause", v);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        exp_push("mid_rst_hnd", 32'd0);      obs_push("mid_rst_hnd", 32'(in_handler_v));
        exp_push("mid_rst_jump_en", 32'd0);  obs_push("mid_rst_jump_en", 32'(jump_en_v));
        for (int a = 0; a < 4; a++) begin
            mfc0(5'(a), v, vf);
            exp_push("mid_rst_reg", 32'd0);
            obs_push("mid_rst_reg", v);
        end
        while (exp_q.size() != 0 || obs_q.size() != 0) begin
            n_assert++;
            if (exp_q.size() == 0 || obs_q.size() == 0) begin
                n_fail++;
                $display("FAIL test_reset_mid scoreboard: exp %0d obs %0d entries", exp_q.size(), obs_q.size());
                exp_q.delete();
                obs_q.delete();
            end else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o.val !== e.val) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, o.val, e.val);
                end
            end
        end
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst      = 1'b1;
        oper     = 2'b00;
        addr_r   = 5'd0;
        addr_w   = 5'd0;
        data_w   = 32'd0;
        ir_en    = 1'b1;
        ir_in    = 4'b0000;
        ret_addr = 32'd0;
        tick();
        test_reset();
        test_irq_take();
        test_priority();
        test_ir_en();
        test_collision();
        test_fixed();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
